// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
package adder_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   // Chunk index width; a single-chunk configuration still needs a 1-bit index.
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder slice with carry out and carry into the slice MSB.
module chunk_add #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   assign {co, s} = {1'b0, x} + {1'b0, y} + (CHUNK+1)'(ci);

   // Carry into the MSB recovered from the MSB sum bit.
   assign c_msb_in = x[CHUNK-1] ^ y[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, start/busy/done handshake.
module chunked_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = idx_width(NCHUNK);
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   generate
      if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_check
         $error("chunked_adder: WIDTH must be >= 2 and a multiple of CHUNK");
      end
   endgenerate

   state_t           state_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
   logic             cout_q, ovf_q, done_q;

   logic [CHUNK-1:0]       slice_s;
   logic                   slice_co, slice_cmsb;
   logic [WIDTH+CHUNK-1:0] acc_cat;
   logic [WIDTH-1:0]       acc_d;

   // Operands shift right so the active slice is always the low CHUNK bits.
   chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
      .x        (a_q[CHUNK-1:0]),
      .y        (b_q[CHUNK-1:0]),
      .ci       (carry_q),
      .s        (slice_s),
      .co       (slice_co),
      .c_msb_in (slice_cmsb)
   );

   // New slice enters at the top of the accumulator; after NCHUNK slices it is aligned.
   always_comb begin
      acc_cat = {slice_s, acc_q};
      acc_d   = acc_cat[WIDTH+CHUNK-1:CHUNK];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? ~cin : cin;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> CHUNK;
               b_q     <= b_q >> CHUNK;
               acc_q   <= acc_d;
               carry_q <= slice_co;
               idx_q   <= idx_q + 1'b1;
               if (idx_q == LAST) begin
                  sum_q   <= acc_d;
                  cout_q  <= slice_co;
                  ovf_q   <= slice_co ^ slice_cmsb;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed and randomized bench for chunked_adder at WIDTH=16, CHUNK=4.
module tb_chunked_adder;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic             busy, done, cout, ovf;
   logic [WIDTH-1:0] sum;

   int ntests = 0;
   int nfail  = 0;

   logic [WIDTH-1:0] prev_s = '0;
   logic             prev_c = 1'b0;
   logic             prev_o = 1'b0;

   chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference from plain integer arithmetic on the operand values.
   function automatic void model(input logic [15:0] ta, input logic [15:0] tb_, input logic tci,
                                 input logic tsub, output logic [15:0] s, output logic co,
                                 output logic ov);
      int sa, sb, ua, ub, r, u;
      sa = int'($signed(ta));
      sb = int'($signed(tb_));
      ua = int'(ta);
      ub = int'(tb_);
      if (!tsub) begin
         r  = sa + sb + int'(tci);
         u  = ua + ub + int'(tci);
         co = (u > 65535);
      end else begin
         r  = sa - sb - int'(tci);
         u  = ua - ub - int'(tci);
         co = (ua >= ub + int'(tci));
      end
      s  = 16'(u);
      ov = (r > 32767) || (r < -32768);
   endfunction

   // One operation; mid pulses a stray start while busy, b2b leaves the bench in the done cycle.
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tci, input logic tsub, input bit mid, input bit b2b);
      logic [15:0] es;
      logic        ec, eo;
      model(ta, tb_, tci, tsub, es, ec, eo);
      @(negedge clk);
      a = ta; b = tb_; cin = tci; sub = tsub; start = 1'b1;
      @(posedge clk); #1;
      check({tag, " accept busy/done"}, 32'({busy, done}), 32'(2'b10));
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      for (int k = 1; k <= NCHUNK; k++) begin
         @(posedge clk); #1;
         if (k < NCHUNK) begin
            check({tag, " running busy/done"}, 32'({busy, done}), 32'(2'b10));
            check({tag, " sum held"}, 32'(sum), 32'(prev_s));
            @(negedge clk);
            start = mid && (k == 1);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         end
      end
      check({tag, " done busy/done"}, 32'({busy, done}), 32'(2'b01));
      check({tag, " sum"}, 32'(sum), 32'(es));
      check({tag, " cout"}, 32'(cout), 32'(ec));
      check({tag, " ovf"}, 32'(ovf), 32'(eo));
      prev_s = es; prev_c = ec; prev_o = eo;
      if (!b2b) begin
         @(posedge clk); #1;
         check({tag, " idle busy/done"}, 32'({busy, done}), 32'(2'b00));
         check({tag, " result kept"}, 32'({cout, ovf, sum}), 32'({prev_c, prev_o, prev_s}));
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'(0));
      check("reset done", 32'(done), 32'(0));
      check("reset sum", 32'(sum), 32'(0));
      check("reset cout/ovf", 32'({cout, ovf}), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      run_op("t1 00ff+1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 0);
      check("t1 literal", 32'({cout, ovf, sum}), 32'({2'b00, 16'h0100}));
      run_op("t2 ffff+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
      check("t2 literal", 32'({cout, ovf, sum}), 32'({2'b10, 16'h0000}));
      run_op("t2 ffff+0+cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 0);
      run_op("t3 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0);
      check("t3 literal", 32'({cout, ovf, sum}), 32'({2'b01, 16'h8000}));
      run_op("t3 8000-1", 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 0);
      check("t3 sub literal", 32'({cout, ovf, sum}), 32'({2'b11, 16'h7FFF}));
      run_op("t4 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 0);
      check("t4 literal", 32'({cout, ovf, sum}), 32'({2'b00, 16'hFFFE}));
      run_op("t4 7-5-1", 16'h0007, 16'h0005, 1'b1, 1'b1, 0, 0);
      check("t4b literal", 32'({cout, sum}), 32'({1'b1, 16'h0001}));

      run_op("t5 mid start", 16'h1357, 16'h2468, 1'b0, 1'b0, 1, 0);
      run_op("t5 b2b first", 16'hABCD, 16'h1111, 1'b1, 1'b0, 0, 1);
      run_op("t5 b2b second", 16'h0F0F, 16'h00F1, 1'b0, 1'b1, 0, 0);

      // Reset two cycles after accept: partial result is dropped.
      @(negedge clk);
      a = 16'h4321; b = 16'h1234; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("t6 reset busy/done", 32'({busy, done}), 32'(2'b00));
      check("t6 reset outputs", 32'({cout, ovf, sum}), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      prev_s = '0; prev_c = 1'b0; prev_o = 1'b0;
      for (int k = 0; k < NCHUNK + 1; k++) begin
         @(posedge clk); #1;
         check("t6 no done after reset", 32'({busy, done}), 32'(2'b00));
      end
      run_op("t6 fresh", 16'h1234, 16'h1111, 1'b0, 1'b0, 0, 0);
      check("t6 literal", 32'(sum), 32'(16'h2345));

      for (int i = 0; i < 24; i++) begin
         run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
